// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - PC sequencer feeding a registered valid/ready fetch stage
// Handles redirect/flush from execute and halt/resume from debug.

module inst_fetch_ctrl #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned INST_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  input  logic              halt_req,
  input  logic              resume,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              can_accept;
  logic              load;

  assign rom_addr   = pc;
  assign can_accept = !out_valid || out_ready;
  assign load       = (state == RUN) && !redir_valid && !halt_req && can_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      out_inst    <= '0;
      out_pc      <= '0;
      out_valid   <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      // Consumption drops valid; a load or redirect below overrides it.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (redir_valid) begin
        pc        <= redir_pc;
        out_valid <= 1'b0;
      end

      if (load) begin
        out_inst  <= rom_inst;
        out_pc    <= pc;
        out_valid <= 1'b1;
        pc        <= pc + PC_ONE;
        if (fetch_count != {CNT_W{1'b1}}) begin
          fetch_count <= fetch_count + CNT_ONE;
        end
      end

      case (state)
        BOOT: begin
          state <= RUN;
        end
        RUN: begin
          if (!redir_valid && halt_req) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        HALT: begin
          // Redirect may coincide with resume; both apply.
          if (resume && !halt_req) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= BOOT;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb/tb_inst_fetch_ctrl.sv - directed self-checking bench for inst_fetch_ctrl

module tb_inst_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [5:0]  rom_addr, rom_addr4;
  logic [31:0] rom_inst, rom_inst4;
  logic [31:0] out_inst, out_inst4;
  logic [5:0]  out_pc, out_pc4;
  logic        out_valid, out_valid4;
  logic        out_ready;
  logic        redir_valid;
  logic [5:0]  redir_pc;
  logic        halt_req;
  logic        resume;
  logic        halted, halted4;
  logic [15:0] fetch_count;
  logic [3:0]  fetch_count4;

  logic [31:0] rom [64];

  int n_tests;
  int n_fail;

  assign rom_inst  = rom[rom_addr];
  assign rom_inst4 = rom[rom_addr4];

  inst_fetch_ctrl #(.ADDR_W(6), .INST_W(32), .RESET_PC(6'd0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .out_inst(out_inst), .out_pc(out_pc), .out_valid(out_valid), .out_ready(out_ready),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .halt_req(halt_req), .resume(resume),
    .halted(halted), .fetch_count(fetch_count)
  );

  inst_fetch_ctrl #(.ADDR_W(6), .INST_W(32), .RESET_PC(6'd0), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .rom_addr(rom_addr4), .rom_inst(rom_inst4),
    .out_inst(out_inst4), .out_pc(out_pc4), .out_valid(out_valid4), .out_ready(out_ready),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .halt_req(halt_req), .resume(resume),
    .halted(halted4), .fetch_count(fetch_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [5:0] pc, input logic [31:0] inst);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_pc"}, 32'(out_pc), 32'(pc));
    check({tag, "_inst"}, out_inst, inst);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 64; i++) rom[i] = 32'hdead0000 | i;
    rom[0] = 32'h00000000;
    rom[1] = 32'h3c000862;
    rom[2] = 32'h00100841;
    rom[3] = 32'h48000001;
    rom[4] = 32'h00100443;
    rom[5] = 32'h04101025;
    rom[6] = 32'h042018e1;

    rst = 1'b1; out_ready = 1'b1; redir_valid = 1'b0; redir_pc = '0;
    halt_req = 1'b0; resume = 1'b0;
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_inst", out_inst, 32'd0);
    check("rst_pc", 32'(out_pc), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_count", 32'(fetch_count), 32'd0);
    check("rst_addr", 32'(rom_addr), 32'd0);

    rst = 1'b0;
    tick();
    check("boot_valid", 32'(out_valid), 32'd0);
    tick(); check_out("seq0", 6'd0, 32'h00000000);
    tick(); check_out("seq1", 6'd1, 32'h3c000862);
    tick(); check_out("seq2", 6'd2, 32'h00100841);
    check("seq_count", 32'(fetch_count), 32'd3);

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out("bp_hold", 6'd2, 32'h00100841);
      check("bp_addr", 32'(rom_addr), 32'd3);
    end
    out_ready = 1'b1;
    tick(); check_out("bp_next", 6'd3, 32'h48000001);
    check("bp_count", 32'(fetch_count), 32'd4);

    out_ready = 1'b0; redir_valid = 1'b1; redir_pc = 6'd1;
    tick();
    check("rd_valid", 32'(out_valid), 32'd0);
    check("rd_addr", 32'(rom_addr), 32'd1);
    check("rd_count", 32'(fetch_count), 32'd4);
    redir_valid = 1'b0; out_ready = 1'b1;
    tick(); check_out("rd_tgt", 6'd1, 32'h3c000862);
    check("rd_count2", 32'(fetch_count), 32'd5);
    tick(); tick();
    tick(); check_out("pre_halt", 6'd4, 32'h00100443);

    out_ready = 1'b0; halt_req = 1'b1;
    tick();
    check("h_halted", 32'(halted), 32'd1);
    check_out("h_hold", 6'd4, 32'h00100443);
    out_ready = 1'b1;
    tick();
    check("h_drain", 32'(out_valid), 32'd0);
    check("h_pc", 32'(rom_addr), 32'd5);
    resume = 1'b1;
    tick();
    check("h_resume_blk", 32'(halted), 32'd1);
    resume = 1'b0; halt_req = 1'b0;
    tick();
    check("h_still", 32'(halted), 32'd1);
    check("h_novalid", 32'(out_valid), 32'd0);
    resume = 1'b1;
    tick();
    check("h_resumed", 32'(halted), 32'd0);
    check("h_res_valid", 32'(out_valid), 32'd0);
    resume = 1'b0;
    tick(); check_out("h_first", 6'd5, 32'h04101025);
    check("h_count", 32'(fetch_count), 32'd9);

    redir_valid = 1'b1; redir_pc = 6'd62;
    tick();
    check("wr_addr", 32'(rom_addr), 32'd62);
    redir_valid = 1'b0;
    tick(); check_out("wr62", 6'd62, 32'hdead003e);
    tick(); check_out("wr63", 6'd63, 32'hdead003f);
    check("wr_addr0", 32'(rom_addr), 32'd0);
    tick(); check_out("wr0", 6'd0, 32'h00000000);
    tick(); check_out("wr1", 6'd1, 32'h3c000862);
    check("wr_count", 32'(fetch_count), 32'd13);

    halt_req = 1'b1;
    tick();
    check("mr_halted", 32'(halted), 32'd1);
    rst = 1'b1; redir_valid = 1'b1; redir_pc = 6'd9;
    tick();
    check("mr_halted0", 32'(halted), 32'd0);
    check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_inst", out_inst, 32'd0);
    check("mr_pc", 32'(out_pc), 32'd0);
    check("mr_count", 32'(fetch_count), 32'd0);
    check("mr_addr", 32'(rom_addr), 32'd0);

    rst = 1'b0; redir_valid = 1'b0; halt_req = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) tick();
    check("sat_count16", 32'(fetch_count), 32'd20);
    check("sat_count4", 32'(fetch_count4), 32'd15);
    check_out("sat_last", 6'd19, 32'hdead0013);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
